// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler: round-robin scheduler sharing one sequential multiplier
// engine among NUM_REQ requesters. Jobs with a zero operand skip the engine.
// Optional watchdog on the engine wait: define MUL_SCHED_TIMEOUT_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. valid, once raised by the source, is not required to stay
// up, since only the accept-cycle payload matters. req_ready is one-hot or
// zero and only asserted in IDLE. rsp_valid and all rsp_* fields stay
// stable until rsp_ready is seen high with rsp_valid.
module mul_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     rsp_err,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     mul_abort,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               mul_start_q, mul_start_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    int unsigned        cand;
    logic [WIDTH-1:0]   sel_a, sel_b;

`ifdef MUL_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               err_q, err_d;
    logic               abort_q, abort_d;
`endif

    // Rotating priority search: first valid requester after the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_idx == ID_W'(j)) begin
                sel_a = req_a[j*WIDTH +: WIDTH];
                sel_b = req_b[j*WIDTH +: WIDTH];
            end
        end
    end

    // Accept strobe: only in IDLE, held off while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (!reset && state_q == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state and next-output computation for the scheduler FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        prod_d       = prod_q;
        rsp_valid_d  = rsp_valid_q;
        mul_start_d  = 1'b0;
`ifdef MUL_SCHED_TIMEOUT_EN
        wdog_d       = wdog_q;
        err_d        = err_q;
        abort_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    last_grant_d = grant_idx;
                    id_d         = grant_idx;
                    a_d          = sel_a;
                    b_d          = sel_b;
`ifdef MUL_SCHED_TIMEOUT_EN
                    err_d        = 1'b0;
`endif
                    if (sel_a == '0 || sel_b == '0) begin
                        prod_d      = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        mul_start_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
`ifdef MUL_SCHED_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the last allowed cycle still wins.
                if (mul_done) begin
                    prod_d      = mul_product;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
`ifdef MUL_SCHED_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    abort_d     = 1'b1;
                    err_d       = 1'b1;
                    prod_d      = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scheduler state and registered outputs; reset discards any job.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            prod_q       <= '0;
            rsp_valid_q  <= 1'b0;
            mul_start_q  <= 1'b0;
`ifdef MUL_SCHED_TIMEOUT_EN
            wdog_q       <= '0;
            err_q        <= 1'b0;
            abort_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            prod_q       <= prod_d;
            rsp_valid_q  <= rsp_valid_d;
            mul_start_q  <= mul_start_d;
`ifdef MUL_SCHED_TIMEOUT_EN
            wdog_q       <= wdog_d;
            err_q        <= err_d;
            abort_q      <= abort_d;
`endif
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_product = prod_q;
    assign mul_start   = mul_start_q;
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state   = state_q;

`ifdef MUL_SCHED_TIMEOUT_EN
    assign rsp_err   = err_q;
    assign mul_abort = abort_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT < 2);
    assign rsp_err        = 1'b0;
    assign mul_abort      = 1'b0;
`endif

endmodule
